// File: rtl/lpc_pkg.sv
// Shared types and helpers for the LPC front end: widths, FSM encoding, 16-bit clamp.
package lpc_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PROD_W   = 32;
  localparam int ACC_W    = 40;
  // Saturation input is widened to a fixed 64 bits so any accumulator width fits.
  localparam int SAT_IN_W = 64;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Clamp a signed value into the signed 16-bit range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] a);
    if (a > 64'sd32767)
      return 16'sh7fff;
    else if (a < -64'sd32768)
      return 16'sh8000;
    else
      return a[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame sample buffer: one write port, two synchronous read ports (1-cycle latency).
module frame_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] mem [DEPTH];

  // Write and both registered reads share the clock; no reset on storage.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/autocorr_frame.sv
// Framed autocorrelation: fill a frame, then one MAC per cycle per lag,
// emitting one scaled/saturated R[k] beat per lag from MIN_LAG to MAX_LAG.
module autocorr_frame
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int MIN_LAG   = 20,
  parameter int MAX_LAG   = 160,
  parameter int SHIFT     = 16,
  parameter int ACC_W     = lpc_pkg::ACC_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic        v,
  output logic        ready,
  output logic [15:0] r,
  output logic [7:0]  lag,
  output logic        vout,
  output logic        frame_done,
  output logic        overrun
);

  localparam int AW = $clog2(FRAME_LEN);

  state_e                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [AW-1:0]             n_q, n_d;
  logic [AW-1:0]             k_q, k_d;
  logic [1:0]                drn_q, drn_d;
  // [0]: read data valid, [1]: product register valid
  logic [1:0]                vld_pipe_q, vld_pipe_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      ready_q, ready_d;
  logic [15:0]               r_q, r_d;
  logic [7:0]                lag_q, lag_d;
  logic                      vout_q, vout_d;
  logic                      fd_q, fd_d;
  logic                      ovr_q, ovr_d;

  logic                      we, issue;
  logic [AW-1:0]             raddr_b;
  logic [15:0]               rd_a, rd_b;
  logic signed [ACC_W-1:0]   acc_sum, acc_sh;

  // Reads for tap pair (n, n-k); issued only in COMPUTE.
  assign raddr_b = n_q - k_q;

  frame_ram #(.DEPTH(FRAME_LEN), .AW(AW), .W(SAMPLE_W)) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (cnt_q),
    .wdata   (x),
    .raddr_a (n_q),
    .raddr_b (raddr_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // Next-state: FSM, counters, MAC pipeline and output registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    k_d        = k_q;
    drn_d      = drn_q;
    ready_d    = ready_q;
    r_d        = r_q;
    lag_d      = lag_q;
    vout_d     = 1'b0;
    fd_d       = 1'b0;
    ovr_d      = ovr_q | (v & ~ready_q);
    we         = 1'b0;
    issue      = 1'b0;
    prod_d     = PROD_W'($signed(rd_a)) * PROD_W'($signed(rd_b));
    acc_sum    = acc_q + ACC_W'(prod_q);
    acc_sh     = acc_sum >>> SHIFT;
    acc_d      = vld_pipe_q[1] ? acc_sum : acc_q;

    unique case (state_q)
      FILL: begin
        if (v) begin
          we    = 1'b1;
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == AW'(FRAME_LEN - 1)) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            n_d     = AW'(MIN_LAG);
            k_d     = AW'(MIN_LAG);
            ready_d = 1'b0;
            acc_d   = '0;
          end
        end
      end
      COMPUTE: begin
        issue = 1'b1;
        n_d   = n_q + AW'(1);
        if (n_q == AW'(FRAME_LEN - 1)) begin
          state_d = EMIT;
          drn_d   = 2'd0;
        end
      end
      EMIT: begin
        drn_d = drn_q + 2'd1;
        if (drn_q == 2'd1) begin
          // Last product of this lag sits in prod_q; fold it in while emitting.
          r_d    = sat16(SAT_IN_W'(acc_sh));
          lag_d  = 8'(k_q);
          vout_d = 1'b1;
          acc_d  = '0;
          if (k_q == AW'(MAX_LAG)) begin
            fd_d = 1'b1;
          end else begin
            state_d = COMPUTE;
            k_d     = k_q + AW'(1);
            n_d     = k_q + AW'(1);
          end
        end else if (drn_q == 2'd2) begin
          // One idle cycle after the final beat keeps ready low during it.
          state_d = FILL;
          ready_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    vld_pipe_d = {vld_pipe_q[0], issue};
  end

  // State registers; synchronous reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      n_q        <= '0;
      k_q        <= '0;
      drn_q      <= '0;
      vld_pipe_q <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      ready_q    <= 1'b1;
      r_q        <= '0;
      lag_q      <= '0;
      vout_q     <= 1'b0;
      fd_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      k_q        <= k_d;
      drn_q      <= drn_d;
      vld_pipe_q <= vld_pipe_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      ready_q    <= ready_d;
      r_q        <= r_d;
      lag_q      <= lag_d;
      vout_q     <= vout_d;
      fd_q       <= fd_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ready      = ready_q;
  assign r          = r_q;
  assign lag        = lag_q;
  assign vout       = vout_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

endmodule
